// File: rtl/lsu_writeback.sv
// Load/store unit between the execute datapath and data memory: one access at a time,
// byte-enabled stores, aligned and extended load writeback to the register file.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | mem_req held until mem_ack or timeout
// WB     | one-cycle register-file write of load data
module lsu_writeback #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_ad3,
  output logic [31:0] rf_wd3,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic          we_r;
  logic [2:0]    f3_r;
  logic [1:0]    off_r;
  logic          accept, legal, timeout_hit;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;
  logic [31:0]   ld_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign mem_req     = (state == ACCESS);
  assign mem_we      = mem_req & we_r;
  assign rf_we       = (state == WB) && (rf_ad3 != 5'd0);
  assign accept      = req_valid && req_ready;
  assign timeout_hit = (state == ACCESS) && !mem_ack && (tmo_cnt == TMO_LAST);

  always_comb begin
    legal = 1'b0;
    if (req_we) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else        legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010)
                     || (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    if (req_funct3[1:0] == 2'b01 && req_addr[0])           legal = 1'b0;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) legal = 1'b0;
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_nxt    = 4'b0001 << req_addr[1:0];
          wdata_nxt = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_nxt    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{req_wdata[15:0]}};
        end
        default: be_nxt = 4'b1111;
      endcase
    end
  end

  always_comb begin
    ld_byte = mem_rdata[8*off_r +: 8];
    ld_half = off_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_r)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'd0, ld_byte};
      3'b101:  ld_val = {16'd0, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && legal) state_nxt = ACCESS;
      ACCESS: begin
        if (mem_ack)          state_nxt = we_r ? IDLE : WB;
        else if (timeout_hit) state_nxt = IDLE;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      tmo_cnt   <= '0;
      we_r      <= 1'b0;
      f3_r      <= 3'b000;
      off_r     <= 2'b00;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'b0000;
      rf_ad3    <= 5'd0;
      rf_wd3    <= 32'd0;
    end else begin
      err <= (accept && !legal) || timeout_hit;
      if (accept && legal) begin
        tmo_cnt   <= '0;
        we_r      <= req_we;
        f3_r      <= req_funct3;
        off_r     <= req_addr[1:0];
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= wdata_nxt;
        mem_be    <= be_nxt;
        rf_ad3    <= req_rd;
      end
      if (state == ACCESS && !mem_ack && !timeout_hit) tmo_cnt <= tmo_cnt + 1'b1;
      // load data is captured on the ack edge so WB drives a registered value
      if (state == ACCESS && mem_ack && !we_r) rf_wd3 <= ld_val;
    end
  end

endmodule

// File: tb/tb_lsu_writeback.sv
// Directed bench for lsu_writeback: loads, stores, illegal requests, timeout,
// x0 writeback suppression and reset mid-access.
module tb_lsu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_ad3;
  logic [31:0] rf_wd3;
  logic        busy, err;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_writeback #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_ad3(rf_ad3), .rf_wd3(rf_wd3), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata, input logic [31:0] exp_maddr,
                         input logic [31:0] exp_wd, input logic exp_rfwe);
    issue(1'b0, f3, addr, 32'd0, rd);
    chk("ld_mem_req", mem_req, 1);
    chk("ld_mem_addr", mem_addr, exp_maddr);
    chk("ld_mem_be", mem_be, 4'hf);
    chk("ld_mem_we", mem_we, 0);
    chk("ld_ready_busy", req_ready, 0);
    mem_ack = 1'b1; mem_rdata = rdata;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("wb_rf_we", rf_we, exp_rfwe);
    chk("wb_mem_req", mem_req, 0);
    chk("wb_busy", busy, 1);
    if (exp_rfwe) begin
      chk("wb_rf_ad3", rf_ad3, rd);
      chk("wb_rf_wd3", rf_wd3, exp_wd);
    end
    step();
    chk("post_wb_rf_we", rf_we, 0);
    chk("post_wb_ready", req_ready, 1);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                          input int ack_dly, input logic [31:0] exp_maddr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    issue(1'b1, f3, addr, data, 5'd7);
    for (int i = 0; i <= ack_dly; i++) begin
      chk("st_mem_req", mem_req, 1);
      chk("st_mem_we", mem_we, 1);
      chk("st_mem_addr", mem_addr, exp_maddr);
      chk("st_mem_be", mem_be, exp_be);
      chk("st_mem_wdata", mem_wdata, exp_wdata);
      chk("st_rf_we", rf_we, 0);
      if (i == ack_dly) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    chk("st_done_req", mem_req, 0);
    chk("st_done_ready", req_ready, 1);
    chk("st_done_rf_we", rf_we, 0);
  endtask

  task automatic do_illegal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    issue(we, f3, addr, 32'h0, 5'd3);
    chk("ill_err", err, 1);
    chk("ill_mem_req", mem_req, 0);
    chk("ill_ready", req_ready, 1);
    step();
    chk("ill_err_clear", err, 0);
    chk("ill_mem_req2", mem_req, 0);
    chk("ill_rf_we", rf_we, 0);
  endtask

  initial begin
    int n_req;
    logic saw_rfwe;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    step(); step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rf_wd3", rf_wd3, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b0;
    step();

    do_load(3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 1'b1);
    do_load(3'b000, 32'h103, 5'd6, 32'h80FF0000, 32'h100, 32'hFFFFFF80, 1'b1);
    do_load(3'b100, 32'h103, 5'd7, 32'h80FF0000, 32'h100, 32'h00000080, 1'b1);
    do_load(3'b001, 32'h102, 5'd8, 32'h80FF0000, 32'h100, 32'hFFFF80FF, 1'b1);
    do_load(3'b101, 32'h100, 5'd9, 32'h1234F00D, 32'h100, 32'h0000F00D, 1'b1);
    do_load(3'b000, 32'h101, 5'd10, 32'h00007F00, 32'h100, 32'h0000007F, 1'b1);
    do_load(3'b010, 32'h104, 5'd0, 32'hCAFEF00D, 32'h104, 32'h0, 1'b0);

    do_store(3'b000, 32'h201, 32'h000000AB, 0, 32'h200, 4'b0010, 32'hABABABAB);
    do_store(3'b001, 32'h202, 32'h00001234, 2, 32'h200, 4'b1100, 32'h12341234);
    do_store(3'b001, 32'h300, 32'hFFFF5678, 0, 32'h300, 4'b0011, 32'h56785678);
    do_store(3'b010, 32'h404, 32'h89ABCDEF, 1, 32'h404, 4'b1111, 32'h89ABCDEF);

    do_illegal(1'b0, 3'b010, 32'h102);
    do_illegal(1'b0, 3'b011, 32'h100);
    do_illegal(1'b0, 3'b001, 32'h101);
    do_illegal(1'b1, 3'b100, 32'h100);

    // timeout: ack never arrives
    issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd4);
    n_req = 0;
    saw_rfwe = 1'b0;
    while (mem_req && n_req < 40) begin
      n_req++;
      if (err) saw_rfwe = 1'b1;
      step();
      if (rf_we) saw_rfwe = 1'b1;
    end
    chk("tmo_req_cycles", n_req, 16);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_no_rfwe_or_early_err", saw_rfwe, 0);
    step();
    chk("tmo_err_clear", err, 0);
    chk("tmo_rf_we", rf_we, 0);

    // reset in the middle of a load access, late ack must be ignored
    issue(1'b0, 3'b010, 32'h600, 32'h0, 5'd12);
    chk("rst_mid_req", mem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11223344;
    chk("rst_mid_req_low", mem_req, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_rf_we", rf_we, 0);
    step();
    mem_ack = 1'b0;
    chk("rst_late_ack_rf_we", rf_we, 0);
    chk("rst_late_ack_busy", busy, 0);
    chk("rst_late_ack_wd3", rf_wd3, 0);
    step();
    chk("rst_after_rf_we", rf_we, 0);

    do_load(3'b010, 32'h700, 5'd31, 32'h0BADC0DE, 32'h700, 32'h0BADC0DE, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
Multi-cycle load/store unit that sits between the execute datapath and data memory. It accepts one load or store request at a time from the datapath (ALU-computed address, rs2 store data, destination rd) and runs a request/acknowledge handshake with data memory. Stores are written with byte enables. For loads, it aligns and sign- or zero-extends the returned data, then drives the register-file write port (WE3/AD3/WD3) for one cycle.

Parameters:
ACK_TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before the access is aborted (must be >= 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  datapath presents a memory request
req_ready  output  1  unit can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  byte address from ALU
req_wdata  input  32  store data (rs2)
req_rd  input  5  load destination register
mem_req  output  1  memory access request, held until ack
mem_we  output  1  memory write strobe
mem_addr  output  32  word-aligned address
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables
mem_ack  input  1  memory completes access (rdata valid same cycle for loads)
mem_rdata  input  32  memory read word
rf_we  output  1  register-file write enable (WE3)
rf_ad3  output  5  register-file write address (AD3)
rf_wd3  output  32  register-file write data (WD3)
busy  output  1  access in progress (state != IDLE)
err  output  1  one-cycle pulse: misaligned, illegal funct3, or timeout

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE. mem_req, mem_we, rf_we, err, busy = 0. mem_addr, mem_wdata, rf_ad3, rf_wd3 = 0. mem_be = 4'b0000. Timeout counter = 0.
- State machine: IDLE, ACCESS, WB.
- req_ready = (state == IDLE). A request is accepted on an edge where req_valid && req_ready. Request fields are latched into internal registers at acceptance.
- Legality check at acceptance:
  - Legal loads: funct3 000, 001, 010, 100, 101.
  - Legal stores: funct3 000, 001, 010.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] != 0.
  - Illegal or misaligned request: stay in IDLE, err = 1 for exactly the next cycle, no memory access, no rf_we.
- IDLE -> ACCESS on a legal acceptance. In ACCESS, mem_req = 1 and mem_addr, mem_we, mem_wdata, mem_be are stable until the edge that samples mem_ack = 1. mem_ack may be high in the first ACCESS cycle.
- Store lane rules:
  - SB: byte replicated to all 4 lanes; be = 1 << addr[1:0].
  - SH: halfword replicated to both halves; be = 0011 if addr[1] = 0, else 1100.
  - SW: be = 1111.
- Loads: mem_we = 0, mem_be = 1111.
- ACCESS exit on mem_ack: store -> IDLE; load -> WB, with the extracted word registered from mem_rdata.
- Load extraction:
  - Byte lane = addr[1:0]; halfword = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- WB lasts exactly one cycle: rf_we = 1, rf_ad3 = rd, rf_wd3 = extracted value; then -> IDLE.
  - If rd == 0, WB is still entered but rf_we stays 0 (x0 is never written).
- Latency: accept edge T; mem_req high in cycle T+1. With mem_ack in T+1, rf_we is high in T+2 and req_ready returns in T+3. Back-to-back throughput is one access per 3 cycles minimum (2 for stores).
- Timeout: counter counts cycles in ACCESS with mem_ack = 0. When it reaches ACK_TIMEOUT: mem_req drops, err pulses one cycle, state -> IDLE, no rf_we. Counter clears on entering ACCESS.
- mem_ack outside ACCESS is ignored.
- rst asserted mid-access: next edge forces IDLE with all outputs at reset values; a pending load is never written back.
- req_valid while busy is ignored; no request is queued.

Test Plan:
- LW addr 0x100, rd = 5, mem_ack in first ACCESS cycle, rdata 0xDEADBEEF -> mem_addr 0x100, be 1111; rf_we = 1 one cycle at T+2, rf_ad3 = 5, rf_wd3 = 0xDEADBEEF.
- LB addr 0x103 / LBU addr 0x103, rdata 0x80FF_0000 -> rf_wd3 = 0xFFFFFF80 / 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201 data 0x000000AB -> mem_addr 0x200, be 0010, wdata 0xABABABAB, mem_we = 1. SH addr 0x202 data 0x1234 -> be 1100, wdata 0x12341234. No rf_we in either case.
- LW addr 0x102 and funct3 011 -> err pulse one cycle, mem_req never asserted, req_ready stays 1.
- LW with mem_ack held 0 and ACK_TIMEOUT = 16 -> mem_req high exactly 16 cycles, then err pulse, IDLE, no rf_we. LW with rd = 0 and valid ack -> memory access occurs, rf_we stays 0.
- rst asserted in ACCESS of a load, mem_ack the following cycle -> mem_req low after reset edge, rf_we never asserted, req_ready = 1 once rst deasserts.
